// File: rtl/nexus_mem_port_ctrl_if.sv
// Bus bundle between the NexusRV16 datapath / program loader, the memory port
// sequencer and unified memory.
interface nexus_mem_port_ctrl_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
);
  logic              sel_in;
  logic              load_valid;
  logic [DATA_W-1:0] load_data;
  logic [ADDR_W-1:0] dp_pc;
  logic              dp_rd;
  logic              dp_wr;
  logic [ADDR_W-1:0] dp_addr;
  logic [DATA_W-1:0] dp_wdata;
  logic              dp_halted;
  logic [DATA_W-1:0] instr_out;
  logic              stall;
  logic [DATA_W-1:0] rdata;
  logic              rdata_valid;
  logic [ADDR_W-1:0] load_count;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output sel_in, load_valid, load_data, dp_pc, dp_rd, dp_wr, dp_addr, dp_wdata,
           dp_halted, mem_rdata,
    input  instr_out, stall, rdata, rdata_valid, load_count, mem_addr, mem_wdata, mem_we
  );

  modport slave (
    input  sel_in, load_valid, load_data, dp_pc, dp_rd, dp_wr, dp_addr, dp_wdata,
           dp_halted, mem_rdata,
    output instr_out, stall, rdata, rdata_valid, load_count, mem_addr, mem_wdata, mem_we
  );
endinterface

// File: rtl/nexus_mem_port_ctrl.sv
// Single-port memory sequencer: shares one memory port between instruction fetch,
// data load/store and program loading, inserting stalls and NOP bubbles as needed.
module nexus_mem_port_ctrl #(
  parameter int                DATA_W        = 16,
  parameter int                ADDR_W        = 16,
  parameter int                WAIT_STATES   = 0,
  parameter int                BUBBLE_CYCLES = 1,
  parameter logic [DATA_W-1:0] NOP_WORD      = '1,
  parameter logic [ADDR_W-1:0] LOAD_BASE     = '0
) (
  input logic                 clk,
  input logic                 rst,
  nexus_mem_port_ctrl_if.slave bus
);

  localparam int WW = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
  localparam int BW = (BUBBLE_CYCLES > 0) ? $clog2(BUBBLE_CYCLES + 1) : 1;
  localparam logic [WW-1:0] WAIT_LAST = WW'(WAIT_STATES);
  localparam logic [BW-1:0] BUB_LAST  = BW'((BUBBLE_CYCLES > 0) ? BUBBLE_CYCLES - 1 : 0);

  typedef enum logic [1:0] {FETCH, DATA, BUBBLE, LOAD} state_t;

  localparam state_t DATA_NEXT = (BUBBLE_CYCLES > 0) ? BUBBLE : FETCH;

  state_t            state;
  logic [WW-1:0]     wait_cnt;
  logic [BW-1:0]     bub_cnt;
  logic              op_wr;
  logic [DATA_W-1:0] rdata_q;
  logic              rdata_valid_q;
  logic [ADDR_W-1:0] load_count_q;
  logic [ADDR_W-1:0] load_cnt_cur;
  logic              data_req;
  logic              wait_done;

  // The first cycle of a load session already writes at LOAD_BASE, before the count clears.
  assign load_cnt_cur = (state == LOAD) ? load_count_q : '0;
  assign data_req     = bus.dp_rd | bus.dp_wr;
  assign wait_done    = (wait_cnt == WAIT_LAST);

  assign bus.rdata       = rdata_q;
  assign bus.rdata_valid = rdata_valid_q;
  assign bus.load_count  = load_count_q;

  // sel_in overrides whatever the FSM is doing in the same cycle, aborting any access.
  always_comb begin
    bus.instr_out = NOP_WORD;
    bus.stall     = 1'b0;
    bus.mem_addr  = bus.dp_pc;
    bus.mem_wdata = bus.dp_wdata;
    bus.mem_we    = 1'b0;
    if (!rst) begin
      bus.instr_out = NOP_WORD;
    end else if (bus.sel_in) begin
      bus.stall     = 1'b1;
      bus.mem_addr  = LOAD_BASE + load_cnt_cur;
      bus.mem_wdata = bus.load_data;
      bus.mem_we    = bus.load_valid;
    end else begin
      case (state)
        FETCH: begin
          if (data_req) begin
            bus.stall = 1'b1;
          end else if (bus.dp_halted) begin
            bus.stall = 1'b0;
          end else if (wait_done) begin
            bus.instr_out = bus.mem_rdata;
          end else begin
            bus.stall = 1'b1;
          end
        end
        DATA: begin
          bus.stall    = 1'b1;
          bus.mem_addr = bus.dp_addr;
          bus.mem_we   = bus.dp_wr;
        end
        BUBBLE: begin
          bus.stall = 1'b0;
        end
        LOAD: begin
          bus.stall    = 1'b1;
          bus.mem_addr = LOAD_BASE + load_count_q;
        end
        default: begin
          bus.stall = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= FETCH;
      wait_cnt      <= '0;
      bub_cnt       <= '0;
      op_wr         <= 1'b0;
      rdata_q       <= '0;
      rdata_valid_q <= 1'b0;
      load_count_q  <= '0;
    end else begin
      rdata_valid_q <= 1'b0;
      if (bus.sel_in) begin
        state        <= LOAD;
        wait_cnt     <= '0;
        bub_cnt      <= '0;
        load_count_q <= load_cnt_cur + ADDR_W'(bus.load_valid);
      end else begin
        case (state)
          FETCH: begin
            if (data_req) begin
              state    <= DATA;
              op_wr    <= bus.dp_wr;
              wait_cnt <= '0;
            end else if (bus.dp_halted || wait_done) begin
              wait_cnt <= '0;
            end else begin
              wait_cnt <= wait_cnt + WW'(1);
            end
          end
          DATA: begin
            if (wait_done) begin
              wait_cnt <= '0;
              bub_cnt  <= '0;
              state    <= DATA_NEXT;
              if (!op_wr) begin
                rdata_q       <= bus.mem_rdata;
                rdata_valid_q <= 1'b1;
              end
            end else begin
              wait_cnt <= wait_cnt + WW'(1);
            end
          end
          BUBBLE: begin
            if (bub_cnt == BUB_LAST) begin
              bub_cnt <= '0;
              state   <= FETCH;
            end else begin
              bub_cnt <= bub_cnt + BW'(1);
            end
          end
          LOAD: begin
            state <= FETCH;
          end
          default: begin
            state <= FETCH;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_nexus_mem_port_ctrl.sv
// Directed bench for nexus_mem_port_ctrl: one instance with default timing and one
// with two wait states, driven from a per-cycle vector table plus a reset sequence.
module tb_nexus_mem_port_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  nexus_mem_port_ctrl_if #(.DATA_W(16), .ADDR_W(16)) bus0 ();
  nexus_mem_port_ctrl_if #(.DATA_W(16), .ADDR_W(16)) bus2 ();

  nexus_mem_port_ctrl u_d0 (.clk(clk), .rst(rst), .bus(bus0));
  nexus_mem_port_ctrl #(.WAIT_STATES(2)) u_d2 (.clk(clk), .rst(rst), .bus(bus2));

  typedef struct {
    bit          d2;
    bit          sel, lv;
    logic [15:0] ld, pc;
    bit          rd, wr;
    logic [15:0] addr, wd;
    bit          halt;
    logic [15:0] mrd;
    logic [15:0] e_instr;
    bit          e_stall;
    logic [15:0] e_maddr, e_wdata;
    bit          e_we, e_rv;
    logic [15:0] e_rdata, e_lcnt;
  } vec_t;

  vec_t  vq[$];
  string names[$];
  int    n_vec = 0;
  int    n_bad = 0;

  function automatic void add(input string nm, input bit d2, input bit sel, input bit lv,
                              input logic [15:0] ld, input logic [15:0] pc, input bit rd,
                              input bit wr, input logic [15:0] addr, input logic [15:0] wd,
                              input bit halt, input logic [15:0] mrd,
                              input logic [15:0] e_instr, input bit e_stall,
                              input logic [15:0] e_maddr, input logic [15:0] e_wdata,
                              input bit e_we, input bit e_rv, input logic [15:0] e_rdata,
                              input logic [15:0] e_lcnt);
    vec_t v;
    v.d2 = d2; v.sel = sel; v.lv = lv; v.ld = ld; v.pc = pc; v.rd = rd; v.wr = wr;
    v.addr = addr; v.wd = wd; v.halt = halt; v.mrd = mrd;
    v.e_instr = e_instr; v.e_stall = e_stall; v.e_maddr = e_maddr; v.e_wdata = e_wdata;
    v.e_we = e_we; v.e_rv = e_rv; v.e_rdata = e_rdata; v.e_lcnt = e_lcnt;
    vq.push_back(v);
    names.push_back(nm);
  endfunction

  task automatic chk(input string tag, input string fld, input logic [15:0] act,
                     input logic [15:0] exp);
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s %s: got %h expected %h", tag, fld, act, exp);
    end
  endtask

  task automatic set0(input vec_t v);
    bus0.sel_in = v.sel; bus0.load_valid = v.lv; bus0.load_data = v.ld; bus0.dp_pc = v.pc;
    bus0.dp_rd = v.rd; bus0.dp_wr = v.wr; bus0.dp_addr = v.addr; bus0.dp_wdata = v.wd;
    bus0.dp_halted = v.halt; bus0.mem_rdata = v.mrd;
  endtask

  task automatic set2(input vec_t v);
    bus2.sel_in = v.sel; bus2.load_valid = v.lv; bus2.load_data = v.ld; bus2.dp_pc = v.pc;
    bus2.dp_rd = v.rd; bus2.dp_wr = v.wr; bus2.dp_addr = v.addr; bus2.dp_wdata = v.wd;
    bus2.dp_halted = v.halt; bus2.mem_rdata = v.mrd;
  endtask

  // Compares every output of one instance against a vector's expected fields.
  task automatic check_outs(input string tag, input bit d2, input vec_t v);
    logic [15:0] a_instr, a_maddr, a_wdata, a_rdata, a_lcnt;
    logic        a_stall, a_we, a_rv;
    if (d2) begin
      a_instr = bus2.instr_out; a_stall = bus2.stall; a_maddr = bus2.mem_addr;
      a_wdata = bus2.mem_wdata; a_we = bus2.mem_we; a_rv = bus2.rdata_valid;
      a_rdata = bus2.rdata; a_lcnt = bus2.load_count;
    end else begin
      a_instr = bus0.instr_out; a_stall = bus0.stall; a_maddr = bus0.mem_addr;
      a_wdata = bus0.mem_wdata; a_we = bus0.mem_we; a_rv = bus0.rdata_valid;
      a_rdata = bus0.rdata; a_lcnt = bus0.load_count;
    end
    n_vec++;
    chk(tag, "instr_out", a_instr, v.e_instr);
    chk(tag, "stall", {15'b0, a_stall}, {15'b0, v.e_stall});
    chk(tag, "mem_addr", a_maddr, v.e_maddr);
    chk(tag, "mem_wdata", a_wdata, v.e_wdata);
    chk(tag, "mem_we", {15'b0, a_we}, {15'b0, v.e_we});
    chk(tag, "rdata_valid", {15'b0, a_rv}, {15'b0, v.e_rv});
    chk(tag, "rdata", a_rdata, v.e_rdata);
    chk(tag, "load_count", a_lcnt, v.e_lcnt);
  endtask

  vec_t idle_v;
  vec_t hv;

  initial begin
    idle_v = '{default: '0};
    idle_v.halt = 1'b1;
    set0(idle_v);
    set2(idle_v);

    //  name          d2 sel lv ld       pc       rd wr addr     wd       hlt mrd      | instr    st maddr    wdata    we rv rdata    lcnt
    add("fetch_a",     0, 0, 0, 16'h0,   16'h0010, 0, 0, 16'h0,   16'h0,   0, 16'h1234, 16'h1234, 0, 16'h0010, 16'h0,   0, 0, 16'h0,   16'h0);
    add("fetch_b",     0, 0, 0, 16'h0,   16'h0011, 0, 0, 16'h0,   16'h0,   0, 16'hA5C3, 16'hA5C3, 0, 16'h0011, 16'h0,   0, 0, 16'h0,   16'h0);
    add("halt_a",      0, 0, 0, 16'h0,   16'h0012, 0, 0, 16'h0,   16'h0,   1, 16'h7777, 16'hFFFF, 0, 16'h0012, 16'h0,   0, 0, 16'h0,   16'h0);
    add("halt_b",      0, 0, 0, 16'h0,   16'h0012, 0, 0, 16'h0,   16'h0,   1, 16'h0000, 16'hFFFF, 0, 16'h0012, 16'h0,   0, 0, 16'h0,   16'h0);
    add("wr_req",      0, 0, 0, 16'h0,   16'h0013, 0, 1, 16'h0200, 16'hBEEF, 0, 16'h1111, 16'hFFFF, 1, 16'h0013, 16'hBEEF, 0, 0, 16'h0,   16'h0);
    add("wr_data",     0, 0, 0, 16'h0,   16'h0013, 0, 1, 16'h0200, 16'hBEEF, 0, 16'h1111, 16'hFFFF, 1, 16'h0200, 16'hBEEF, 1, 0, 16'h0,   16'h0);
    add("wr_bub_hold", 0, 0, 0, 16'h0,   16'h0014, 0, 1, 16'h0201, 16'h0001, 0, 16'h2222, 16'hFFFF, 0, 16'h0014, 16'h0001, 0, 0, 16'h0,   16'h0);
    add("wr2_req",     0, 0, 0, 16'h0,   16'h0014, 0, 1, 16'h0201, 16'h0001, 0, 16'h2222, 16'hFFFF, 1, 16'h0014, 16'h0001, 0, 0, 16'h0,   16'h0);
    add("wr2_data",    0, 0, 0, 16'h0,   16'h0014, 0, 1, 16'h0201, 16'h0001, 0, 16'h2222, 16'hFFFF, 1, 16'h0201, 16'h0001, 1, 0, 16'h0,   16'h0);
    add("wr2_bub",     0, 0, 0, 16'h0,   16'h0014, 0, 0, 16'h0,   16'h0,   0, 16'h2222, 16'hFFFF, 0, 16'h0014, 16'h0,   0, 0, 16'h0,   16'h0);
    add("fetch_c",     0, 0, 0, 16'h0,   16'h0014, 0, 0, 16'h0,   16'h0,   0, 16'h2222, 16'h2222, 0, 16'h0014, 16'h0,   0, 0, 16'h0,   16'h0);
    add("rd_req",      0, 0, 0, 16'h0,   16'h0015, 1, 0, 16'h0040, 16'h0,   0, 16'h3333, 16'hFFFF, 1, 16'h0015, 16'h0,   0, 0, 16'h0,   16'h0);
    add("rd_data",     0, 0, 0, 16'h0,   16'h0015, 1, 0, 16'h0040, 16'h0,   0, 16'hC0DE, 16'hFFFF, 1, 16'h0040, 16'h0,   0, 0, 16'h0,   16'h0);
    add("rd_bub",      0, 0, 0, 16'h0,   16'h0016, 0, 0, 16'h0,   16'h0,   0, 16'h4444, 16'hFFFF, 0, 16'h0016, 16'h0,   0, 1, 16'hC0DE, 16'h0);
    add("rd_fetch",    0, 0, 0, 16'h0,   16'h0016, 0, 0, 16'h0,   16'h0,   0, 16'h4444, 16'h4444, 0, 16'h0016, 16'h0,   0, 0, 16'hC0DE, 16'h0);
    add("ld_a0",       0, 1, 1, 16'hA0A0, 16'h0017, 0, 0, 16'h0,   16'h0,   0, 16'h0,    16'hFFFF, 1, 16'h0000, 16'hA0A0, 1, 0, 16'hC0DE, 16'h0);
    add("ld_a1",       0, 1, 1, 16'hA1A1, 16'h0017, 0, 0, 16'h0,   16'h0,   0, 16'h0,    16'hFFFF, 1, 16'h0001, 16'hA1A1, 1, 0, 16'hC0DE, 16'h1);
    add("ld_a2",       0, 1, 1, 16'hA2A2, 16'h0017, 0, 0, 16'h0,   16'h0,   0, 16'h0,    16'hFFFF, 1, 16'h0002, 16'hA2A2, 1, 0, 16'hC0DE, 16'h2);
    add("ld_gap",      0, 1, 0, 16'hDEAD, 16'h0017, 0, 0, 16'h0,   16'h0,   0, 16'h0,    16'hFFFF, 1, 16'h0003, 16'hDEAD, 0, 0, 16'hC0DE, 16'h3);
    add("ld_a3",       0, 1, 1, 16'hA3A3, 16'h0017, 0, 0, 16'h0,   16'h0,   0, 16'h0,    16'hFFFF, 1, 16'h0003, 16'hA3A3, 1, 0, 16'hC0DE, 16'h3);
    add("ld_exit",     0, 0, 0, 16'h0,   16'h0020, 0, 0, 16'h0,   16'h0,   0, 16'h5555, 16'hFFFF, 1, 16'h0004, 16'h0,   0, 0, 16'hC0DE, 16'h4);
    add("ld_fetch",    0, 0, 0, 16'h0,   16'h0020, 0, 0, 16'h0,   16'h0,   0, 16'h5555, 16'h5555, 0, 16'h0020, 16'h0,   0, 0, 16'hC0DE, 16'h4);
    add("reld",        0, 1, 1, 16'hB0B0, 16'h0020, 0, 0, 16'h0,   16'h0,   0, 16'h5555, 16'hFFFF, 1, 16'h0000, 16'hB0B0, 1, 0, 16'hC0DE, 16'h4);
    add("reld_exit",   0, 0, 0, 16'h0,   16'h0020, 0, 0, 16'h0,   16'h0,   0, 16'h5555, 16'hFFFF, 1, 16'h0001, 16'h0,   0, 0, 16'hC0DE, 16'h1);
    add("ab_req",      0, 0, 0, 16'h0,   16'h0021, 1, 0, 16'h0050, 16'h0,   0, 16'h3333, 16'hFFFF, 1, 16'h0021, 16'h0,   0, 0, 16'hC0DE, 16'h1);
    add("ab_load",     0, 1, 1, 16'hD0D0, 16'h0021, 1, 0, 16'h0050, 16'h0,   0, 16'hEEEE, 16'hFFFF, 1, 16'h0000, 16'hD0D0, 1, 0, 16'hC0DE, 16'h1);
    add("ab_exit",     0, 0, 0, 16'h0,   16'h0021, 0, 0, 16'h0,   16'h0,   0, 16'h6666, 16'hFFFF, 1, 16'h0001, 16'h0,   0, 0, 16'hC0DE, 16'h1);
    add("ab_fetch",    0, 0, 0, 16'h0,   16'h0021, 0, 0, 16'h0,   16'h0,   0, 16'h6666, 16'h6666, 0, 16'h0021, 16'h0,   0, 0, 16'hC0DE, 16'h1);
    add("w_f1",        1, 0, 0, 16'h0,   16'h0030, 0, 0, 16'h0,   16'h0,   0, 16'h9999, 16'hFFFF, 1, 16'h0030, 16'h0,   0, 0, 16'h0,   16'h0);
    add("w_f2",        1, 0, 0, 16'h0,   16'h0030, 0, 0, 16'h0,   16'h0,   0, 16'h9999, 16'hFFFF, 1, 16'h0030, 16'h0,   0, 0, 16'h0,   16'h0);
    add("w_f3",        1, 0, 0, 16'h0,   16'h0030, 0, 0, 16'h0,   16'h0,   0, 16'h9999, 16'h9999, 0, 16'h0030, 16'h0,   0, 0, 16'h0,   16'h0);
    add("w_f4",        1, 0, 0, 16'h0,   16'h0031, 0, 0, 16'h0,   16'h0,   0, 16'h8888, 16'hFFFF, 1, 16'h0031, 16'h0,   0, 0, 16'h0,   16'h0);
    add("w_halt",      1, 0, 0, 16'h0,   16'h0031, 0, 0, 16'h0,   16'h0,   1, 16'h8888, 16'hFFFF, 0, 16'h0031, 16'h0,   0, 0, 16'h0,   16'h0);
    add("w_rd_req",    1, 0, 0, 16'h0,   16'h0032, 1, 0, 16'h0300, 16'h0,   0, 16'h0000, 16'hFFFF, 1, 16'h0032, 16'h0,   0, 0, 16'h0,   16'h0);
    add("w_rd_d1",     1, 0, 0, 16'h0,   16'h0032, 1, 0, 16'h0300, 16'h0,   0, 16'h0000, 16'hFFFF, 1, 16'h0300, 16'h0,   0, 0, 16'h0,   16'h0);
    add("w_rd_d2",     1, 0, 0, 16'h0,   16'h0032, 1, 0, 16'h0300, 16'h0,   0, 16'h0F0F, 16'hFFFF, 1, 16'h0300, 16'h0,   0, 0, 16'h0,   16'h0);
    add("w_rd_d3",     1, 0, 0, 16'h0,   16'h0032, 1, 0, 16'h0300, 16'h0,   0, 16'h5A5A, 16'hFFFF, 1, 16'h0300, 16'h0,   0, 0, 16'h0,   16'h0);
    add("w_rd_bub",    1, 0, 0, 16'h0,   16'h0033, 0, 0, 16'h0,   16'h0,   0, 16'h0000, 16'hFFFF, 0, 16'h0033, 16'h0,   0, 1, 16'h5A5A, 16'h0);
    add("w_fetch",     1, 0, 0, 16'h0,   16'h0033, 0, 0, 16'h0,   16'h0,   0, 16'h0000, 16'hFFFF, 1, 16'h0033, 16'h0,   0, 0, 16'h5A5A, 16'h0);
    add("w_wr_req",    1, 0, 0, 16'h0,   16'h0033, 0, 1, 16'h0304, 16'h1357, 0, 16'h0000, 16'hFFFF, 1, 16'h0033, 16'h1357, 0, 0, 16'h5A5A, 16'h0);
    add("w_wr_d1",     1, 0, 0, 16'h0,   16'h0033, 0, 1, 16'h0304, 16'h1357, 0, 16'h0000, 16'hFFFF, 1, 16'h0304, 16'h1357, 1, 0, 16'h5A5A, 16'h0);
    add("w_abort",     1, 1, 0, 16'h2468, 16'h0033, 0, 1, 16'h0304, 16'h1357, 0, 16'h0000, 16'hFFFF, 1, 16'h0000, 16'h2468, 0, 0, 16'h5A5A, 16'h0);
    add("w_ld",        1, 1, 1, 16'h2468, 16'h0033, 0, 0, 16'h0,   16'h0,   0, 16'h0000, 16'hFFFF, 1, 16'h0000, 16'h2468, 1, 0, 16'h5A5A, 16'h0);
    add("w_ld_exit",   1, 0, 0, 16'h0,   16'h0034, 0, 0, 16'h0,   16'h0,   0, 16'h0000, 16'hFFFF, 1, 16'h0001, 16'h0,   0, 0, 16'h5A5A, 16'h1);
    add("w_ld_fetch",  1, 0, 0, 16'h0,   16'h0034, 0, 0, 16'h0,   16'h0,   0, 16'h7777, 16'hFFFF, 1, 16'h0034, 16'h0,   0, 0, 16'h5A5A, 16'h1);

    // Reset held: outputs forced quiet even with a live fetch presented.
    repeat (2) @(posedge clk);
    @(negedge clk);
    hv = idle_v; hv.halt = 1'b0; hv.pc = 16'h0010; hv.mrd = 16'h1234;
    set0(hv);
    #1;
    hv.e_instr = 16'hFFFF; hv.e_stall = 1'b0; hv.e_maddr = 16'h0010; hv.e_wdata = 16'h0;
    hv.e_we = 1'b0; hv.e_rv = 1'b0; hv.e_rdata = 16'h0; hv.e_lcnt = 16'h0;
    check_outs("reset_d0", 1'b0, hv);
    hv = idle_v;
    hv.e_instr = 16'hFFFF;
    check_outs("reset_d2", 1'b1, hv);
    set0(idle_v);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      if (vq[i].d2) begin
        set0(idle_v);
        set2(vq[i]);
      end else begin
        set2(idle_v);
        set0(vq[i]);
      end
      #1;
      check_outs(names[i], vq[i].d2, vq[i]);
    end

    // Reset asserted in the middle of a wait-state store: outputs drop at once, no retry.
    @(negedge clk);
    hv = idle_v; hv.halt = 1'b0; hv.wr = 1'b1; hv.addr = 16'h0400; hv.wd = 16'hAAAA;
    hv.pc = 16'h0040; hv.mrd = 16'h4321;
    set2(hv);
    #1;
    hv.e_instr = 16'hFFFF; hv.e_stall = 1'b1; hv.e_maddr = 16'h0040; hv.e_wdata = 16'hAAAA;
    hv.e_we = 1'b0; hv.e_rv = 1'b0; hv.e_rdata = 16'h5A5A; hv.e_lcnt = 16'h1;
    check_outs("mr_req", 1'b1, hv);
    @(negedge clk);
    #1;
    hv.e_maddr = 16'h0400; hv.e_we = 1'b1;
    check_outs("mr_data", 1'b1, hv);
    #2;
    rst = 1'b0;
    #1;
    hv.e_stall = 1'b0; hv.e_maddr = 16'h0040; hv.e_we = 1'b0; hv.e_rdata = 16'h0;
    hv.e_lcnt = 16'h0;
    check_outs("mr_in_reset", 1'b1, hv);
    @(negedge clk);
    rst = 1'b1;
    hv.wr = 1'b0; hv.wd = 16'h0;
    set2(hv);
    hv.e_wdata = 16'h0;
    for (int c = 0; c < 3; c++) begin
      #1;
      hv.e_stall = (c < 2);
      hv.e_instr = (c < 2) ? 16'hFFFF : 16'h4321;
      check_outs("mr_refetch", 1'b1, hv);
      @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
